// File: rtl/p_transformation_pkg.sv
// Shared definitions for the permutation/key-mixing stage: default sizes,
// FSM encoding and the round-key rotation helper.
package p_transformation_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ROUNDS = 4;
  // Widest datapath the rotation helper supports.
  localparam int MAX_WIDTH  = 64;

  typedef enum logic {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Rotate the low w bits of v left by 2; bits at and above w return 0.
  function automatic logic [MAX_WIDTH-1:0] rotl2(input logic [MAX_WIDTH-1:0] v,
                                                 input int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = v[(i + w - 2) % w];
    end
    return r;
  endfunction

endpackage

// File: rtl/p_perm.sv
// Fixed bit permutation P: even input bits go to the upper half and odd input
// bits go to the lower half. Purely combinational, so the inverse path can reuse it.
module p_perm #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] permuted
);

  always_comb begin
    // NOTE: a default assignment before the loop keeps every bit driven on
    // every path, so no latch is inferred.
    permuted = '0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      permuted[WIDTH/2 + k] = word[2*k];
      permuted[k]           = word[2*k + 1];
    end
  end

endmodule

// File: rtl/p_transformation.sv
// Permutation/key-mixing stage: P(in_data) XOR a rotating round key, with a
// registered valid/ready output and a round counter.
module p_transformation
  import p_transformation_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ROUNDS = DEF_ROUNDS,
  localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RW-1:0]    out_round
);

  state_t           state, state_next;
  logic [WIDTH-1:0] master_key;
  logic [WIDTH-1:0] rk;
  logic [RW-1:0]    round;
  logic [WIDTH-1:0] permuted;
  logic             acc;
  logic             last_round;

  p_perm #(.WIDTH(WIDTH)) u_perm (
    .word     (in_data),
    .permuted (permuted)
  );

  // NOTE: every clocked register uses non-blocking assignments, so all of
  // them see values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOKEY;
    else        state <= state_next;
  end

  // Only reset leaves RUN; key_load both arms the stage and reloads the key.
  always_comb begin
    state_next = state;
    if (key_load) state_next = RUN;
  end

  always_comb begin
    in_ready = (state == RUN) && !key_load && (!out_valid || out_ready);
  end

  assign acc        = in_valid && in_ready;
  assign last_round = (round == RW'(ROUNDS - 1));

  // The round key is kept pre-rotated so the datapath needs no barrel shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_key <= '0;
      rk         <= '0;
      round      <= '0;
    end else if (key_load) begin
      master_key <= key;
      rk         <= key;
      round      <= '0;
    end else if (acc) begin
      if (last_round) begin
        rk    <= master_key;
        round <= '0;
      end else begin
        rk    <= WIDTH'(rotl2(MAX_WIDTH'(rk), WIDTH));
        round <= round + RW'(1);
      end
    end
  end

  // A new acceptance overwrites a result being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= permuted ^ rk;
      out_round <= round;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_transformation.sv
// Self-checking bench for p_transformation: directed scenarios followed by
// randomized traffic compared against a word-level reference model.
module tb_p_transformation;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_load;
  logic [W-1:0]  key;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_round;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit       m_run;
  bit [W-1:0] m_master;
  int       m_round;
  bit       m_ov;
  bit [W-1:0] m_od;
  int       m_or;

  p_transformation #(.WIDTH(W), .ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [W-1:0] rotl_n(input bit [W-1:0] v, input int n);
    bit [W-1:0] r = v;
    repeat (n) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  // Collect even bits (ascending) into the upper half, odd bits into the lower half.
  function automatic bit [W-1:0] perm_ref(input bit [W-1:0] v);
    bit [W/2-1:0] evens = '0;
    bit [W/2-1:0] odds  = '0;
    for (int k = 0; k < W / 2; k++) begin
      evens[k] = v[2*k];
      odds[k]  = v[2*k+1];
    end
    return {evens, odds};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_master = '0; m_round = 0;
    m_ov = 0; m_od = '0; m_or = 0;
  endfunction

  // One clock cycle: drive inputs, check in_ready, clock, check outputs.
  task automatic step(input string tag, input bit kl, input bit [W-1:0] k,
                      input bit iv, input bit [W-1:0] d, input bit ordy);
    bit exp_ready;
    key_load  = kl;
    key       = k;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ready = m_run && !kl && (!m_ov || ordy);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (kl) begin
      m_run = 1; m_master = k; m_round = 0;
    end else if (iv && exp_ready) begin
      m_od    = perm_ref(d) ^ rotl_n(m_master, (2 * m_round) % W);
      m_or    = m_round;
      m_ov    = 1;
      m_round = (m_round + 1) % R;
    end
    if (!(iv && exp_ready) && m_ov && ordy) m_ov = 0;
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, ".out_data"},  32'(out_data),  32'(m_od));
    check({tag, ".out_round"}, 32'(out_round), 32'(m_or));
  endtask

  initial begin
    bit [W-1:0] seq [5] = '{8'hB1, 8'hC6, 8'h1B, 8'h6C, 8'hB1};
    rst_n = 1'b0; key_load = 0; key = '0; in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data",  32'(out_data),  32'd0);
    check("reset.in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // No key held: traffic refused.
    for (int i = 0; i < 5; i++) step("nokey", 0, '0, 1, 8'hB4, 1);

    // Single word.
    step("key_b1", 1, 8'hB1, 0, '0, 1);
    step("single", 0, '0, 1, 8'hB4, 1);
    check("single.value", 32'(out_data), 32'h0000_00DD);
    check("single.round", 32'(out_round), 32'd0);

    // Round sequence from a fresh key.
    step("key_b1b", 1, 8'hB1, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      step("rseq", 0, '0, 1, 8'h00, 1);
      check("rseq.value", 32'(out_data), 32'(seq[i]));
      check("rseq.round", 32'(out_round), 32'(i % R));
    end

    // Backpressure.
    step("key_bp", 1, 8'hB1, 0, '0, 1);
    step("bp_first", 0, '0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 0, '0, 1, 8'h00, 0);
      check("bp_hold.value", 32'(out_data), 32'h0000_00B1);
    end
    step("bp_release", 0, '0, 1, 8'h00, 1);
    check("bp_release.value", 32'(out_data), 32'h0000_00C6);
    step("bp_drain", 0, '0, 0, '0, 1);

    // Key reload after two words, with in_valid high during key_load.
    step("kr_key", 1, 8'hB1, 0, '0, 1);
    step("kr_w0", 0, '0, 1, 8'h00, 1);
    step("kr_w1", 0, '0, 1, 8'h00, 1);
    step("kr_load", 1, 8'h0F, 1, 8'h00, 1);
    step("kr_load2", 1, 8'h0F, 1, 8'h00, 1);
    step("kr_next", 0, '0, 1, 8'h00, 1);
    check("kr_next.value", 32'(out_data), 32'h0000_000F);
    check("kr_next.round", 32'(out_round), 32'd0);

    // Async reset mid-stream while a result is pending.
    step("ar_pend", 0, '0, 1, 8'h5A, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.out_data",  32'(out_data),  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("ar_nokey", 0, '0, 1, 8'h33, 1);
    step("ar_key", 1, 8'h96, 0, '0, 1);
    step("ar_resume", 0, '0, 1, 8'h33, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
           W'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p_transformation.md
# p_transformation

Permutation/key-mixing stage sitting directly downstream of the S-box substitution stage in the toy SP-cipher datapath. It accepts one substituted word per handshake and applies a fixed bit permutation. It then XORs the result with a per-round key derived by rotating a loaded master key, and presents the result on a registered valid/ready output. A round counter tracks the position of each word within the cipher's round sequence.

## Interface
- WIDTH, 8, datapath width in bits; even, ≥4
- ROUNDS, 4, rounds per cycle of the round counter; ≥1
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- key_load  in  1  load `key` as master key; single-cycle strobe
- key  in  WIDTH  master key value, sampled when key_load=1
- in_valid  in  1  upstream word available
- in_ready  out  1  stage can accept a word this cycle
- in_data  in  WIDTH  substituted word from S stage
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  permuted, key-mixed word
- out_round  out  clog2(ROUNDS) (min 1)  round index used for out_data

## Operation
- FSM states:
  - NOKEY (reset state): no key held; in_ready=0.
  - RUN: key held.
  - Transitions: NOKEY→RUN on key_load. RUN→RUN on key_load, which reloads the key. Only Rst_n leaves RUN.
- Accept: `acc = in_valid && in_ready`.
- `in_ready = (state==RUN) && !key_load && (!out_valid || out_ready)`. This is combinational. key_load blocks acceptance in the same cycle.
- Permutation P, defined for k = 0..WIDTH/2-1:
  - out bit (WIDTH/2+k) = in bit 2k (even bits to the upper half)
  - out bit k = in bit 2k+1 (odd bits to the lower half)
- Round key:
  - `rk = rotl(master_key, (2*round) mod WIDTH)`.
  - Held in a register that is rotated left by 2 on each acc.
  - When round wraps from ROUNDS-1 to 0, rk is reloaded from master_key.
- On acc:
  - out_data ← P(in_data) XOR rk
  - out_round ← round
  - out_valid ← 1
  - round ← (round==ROUNDS-1) ? 0 : round+1
- On key_load:
  - master_key ← key
  - rk ← key
  - round ← 0
  - A result already in the output register is unaffected and keeps its values until consumed.
- Output consumption: if out_valid && out_ready && !acc, then out_valid ← 0.
- Output consumption with acc in the same cycle: the new result replaces the old one and out_valid stays 1. This gives full throughput.
- No combinational path from in_data to out_data.

## Timing
- Reset values:
  - state=NOKEY, in_ready=0, out_valid=0, out_data=0, out_round=0
  - round=0, master_key=0, rk=0
- Latency is 1 cycle: a word accepted at edge n appears on out_data with out_valid=1 after edge n.
- Throughput is 1 word/cycle while out_ready=1.
- Backpressure:
  - With out_valid=1 and out_ready=0, in_ready=0.
  - out_data and out_round hold stable until out_ready=1.
- Key timing:
  - key_load at edge n: first acceptance possible at edge n+1, using round 0 of the new key.
  - Back-to-back key_load strobes: the last one wins, and in_ready stays 0 for each strobed cycle.
- Reset assertion mid-operation:
  - Immediately clears all state, including any pending output, and the key is lost.
  - After release, key_load is required before traffic resumes.
- Round wrap: the word accepted with round=ROUNDS-1 uses rotl by 2*(ROUNDS-1). The next word uses master_key unrotated.
- ROUNDS=1: round is always 0 and rk is always master_key.

## Structure
- Shared package p_transformation_pkg holds:
  - WIDTH/ROUNDS defaults
  - FSM state encoding (NOKEY=1'b0, RUN=1'b1)
  - rotate-left-by-2 helper function
- One combinational sub-module, p_perm (WIDTH parameter), implements P. It is reusable by the inverse-path team.
- Top module contains the FSM, round counter, rk register and output register.

## Test plan
- **Reset/no key:** after Rst_n release with in_valid=1, in_data=8'hB4 for 5 cycles → in_ready=0, out_valid=0, out_data=0 throughout.
- **Single word:** key_load with key=8'hB1, then in_data=8'hB4 → out_data=8'hDD, out_round=0, one cycle after acceptance.
- **Round sequence:** key=8'hB1, five in_data=8'h00 words with out_ready=1 → out_data sequence B1, C6, 1B, 6C, B1 and out_round 0,1,2,3,0, all on consecutive cycles.
- **Backpressure:** hold out_ready=0 after the first result → in_ready=0 and out_data held at 8'hB1. Release → next word accepted in the same cycle, no loss or duplication.
- **Key reload:**
  - Apply key_load (key=8'h0F) after two words, together with in_valid=1 → that cycle is not accepted.
  - Next in_data=8'h00 → out_data=8'h0F, out_round=0.
- **Async reset mid-stream:** assert Rst_n=0 between clock edges while out_valid=1 → out_valid drops immediately. After release, traffic is refused until key_load.
